ppm_rr_scheduler: RTL and testbench

- Shares one PPM partial-product multiplier between NREQ requesters.
- Requesters present signed or unsigned N x M operand pairs with valid/ready.
- A round-robin arbiter grants one requester per cycle into a 2-stage pipeline: operand register, then PPM carry-save register.
- The final carry-save add produces the tagged product. It sits between the DSP front-end request ports and the shared PPM multiplier.

---
 rtl/ppm_sched_pkg.sv | 12 +
 rtl/PPM.sv | 39 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/ppm_rr_scheduler.sv | 129 ++++++++++++
 tb/tb_ppm_rr_scheduler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppm_sched_pkg.sv
// Shared sizing helpers for the round-robin PPM scheduler.
package ppm_sched_pkg;

   function automatic int unsigned idw_f(input int unsigned nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   function automatic int unsigned res_w_f(input int unsigned n, input int unsigned m);
      return n + m;
   endfunction

endpackage

// File: rtl/PPM.sv
// Partial-product multiplier: reduces all partial products to a carry-save pair.
// out1 + out2 equals a*b modulo 2^(N+M), signed or unsigned.
module PPM #(
   parameter int unsigned N      = 5,
   parameter int unsigned M      = 5,
   parameter int unsigned SIGNED = 1
) (
   input  logic [N-1:0]   a,
   input  logic [M-1:0]   b,
   output logic [N+M-1:0] out1,
   output logic [N+M-1:0] out2
);

   localparam int unsigned W = N + M;

   logic [W-1:0] a_ext, b_ext;
   logic [W-1:0] s, c, pp, t;

   // Sign extension to the full result width makes modulo-2^W products exact.
   assign a_ext = {{M{(SIGNED != 0) & a[N-1]}}, a};
   assign b_ext = {{N{(SIGNED != 0) & b[M-1]}}, b};

   always_comb begin
      s  = '0;
      c  = '0;
      pp = '0;
      t  = '0;
      for (int j = 0; j < W; j++) begin
         pp = b_ext[j] ? (a_ext << j) : '0;
         t  = s ^ c ^ pp;
         c  = ((s & c) | (s & pp) | (c & pp)) << 1;
         s  = t;
      end
   end

   assign out1 = s;
   assign out2 = c;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter
   import ppm_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = idw_f(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o,
   output logic            any_gnt_o
);

   logic           found;
   logic [IDW-1:0] idx;
   int unsigned    cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr_i) + k) % NREQ;
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      any_gnt_o = found & en_i;
      gnt_idx_o = idx;
      gnt_o     = '0;
      if (any_gnt_o) begin
         gnt_o[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/ppm_rr_scheduler.sv
// Shares one PPM multiplier between NREQ requesters through a round-robin arbiter
// and a two-stage (operand, carry-save) pipeline with valid/ready backpressure.
module ppm_rr_scheduler
   import ppm_sched_pkg::*;
#(
   parameter int unsigned N      = 5,
   parameter int unsigned M      = 5,
   parameter int unsigned SIGNED = 1,
   parameter int unsigned NREQ   = 4,
   parameter int unsigned IDW    = idw_f(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*N-1:0]     req_a,
   input  logic [NREQ*M-1:0]     req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [N+M-1:0]        res_data,
   output logic [IDW-1:0]        res_id
);

   localparam int unsigned W = res_w_f(N, M);

   logic            s1_en, s2_en;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            accept;
   logic [W-1:0]    ppm_out1, ppm_out2;

   logic           s1_valid_q, s1_valid_d;
   logic [N-1:0]   s1_a_q, s1_a_d;
   logic [M-1:0]   s1_b_q, s1_b_d;
   logic [IDW-1:0] s1_id_q, s1_id_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic           s2_valid_q, s2_valid_d;
   logic [W-1:0]   s2_out1_q, s2_out1_d;
   logic [W-1:0]   s2_out2_q, s2_out2_d;
   logic [IDW-1:0] s2_id_q, s2_id_d;

   assign s2_en = !s2_valid_q | res_ready;
   assign s1_en = !s1_valid_q | s2_en;

   // Grants are suppressed while reset is held so req_ready reads 0 during reset.
   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i     (req_valid),
      .ptr_i     (rr_ptr_q),
      .en_i      (s1_en & ~rst),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_gnt_o (accept)
   );

   assign req_ready = gnt;

   PPM #(
      .N      (N),
      .M      (M),
      .SIGNED (SIGNED)
   ) u_ppm (
      .a    (s1_a_q),
      .b    (s1_b_q),
      .out1 (ppm_out1),
      .out2 (ppm_out2)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_id_d    = s1_id_q;
      rr_ptr_d   = rr_ptr_q;
      if (s1_en) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_a_d   = req_a[gnt_idx*N +: N];
            s1_b_d   = req_b[gnt_idx*M +: M];
            s1_id_d  = gnt_idx;
            rr_ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_out1_d  = s2_out1_q;
      s2_out2_d  = s2_out2_q;
      s2_id_d    = s2_id_q;
      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         s2_out1_d  = ppm_out1;
         s2_out2_d  = ppm_out2;
         s2_id_d    = s1_id_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
         rr_ptr_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_out1_q  <= '0;
         s2_out2_q  <= '0;
         s2_id_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_id_q    <= s1_id_d;
         rr_ptr_q   <= rr_ptr_d;
         s2_valid_q <= s2_valid_d;
         s2_out1_q  <= s2_out1_d;
         s2_out2_q  <= s2_out2_d;
         s2_id_q    <= s2_id_d;
      end
   end

   assign res_valid = s2_valid_q;
   assign res_data  = s2_out1_q + s2_out2_q;
   assign res_id    = s2_id_q;

endmodule

// File: tb/tb_ppm_rr_scheduler.sv
// Scoreboard bench for ppm_rr_scheduler: accepts push expected results, a monitor
// pops and compares whenever a result is presented.
module tb_ppm_rr_scheduler;

   localparam int N    = 5;
   localparam int M    = 5;
   localparam int NREQ = 4;
   localparam int W    = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid, req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*M-1:0] req_b;
   logic              res_valid, res_ready;
   logic [W-1:0]      res_data;
   logic [1:0]        res_id;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   use_model = 1'b0;
   int   acc_cnt = 0;

   always #5 clk = ~clk;

   ppm_rr_scheduler #(
      .N      (N),
      .M      (M),
      .SIGNED (1),
      .NREQ   (NREQ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [M-1:0] b);
      int av, bv, p;
      av = a[N-1] ? int'(a) - 32 : int'(a);
      bv = b[M-1] ? int'(b) - 32 : int'(b);
      p  = av * bv;
      return p[W-1:0];
   endfunction

   function automatic int gidx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Accept observer: handshake visible at the negedge is taken at the next posedge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int g = 0; g < NREQ; g++) begin
            if (req_valid[g] && req_ready[g]) begin
               exp_t e;
               acc_cnt++;
               e.id   = 2'(g);
               e.data = model(req_a[g*N +: N], req_b[g*M +: M]);
               if (use_model) exp_q.push_back(e);
            end
         end
      end
   end

   // Result monitor.
   always @(negedge clk) begin
      if (!rst && res_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_result: id %0d data %0h with empty scoreboard", res_id, res_data);
         end else if (res_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_data", 32'(res_data), 32'(e.data));
         end else begin
            chk("stall_id", 32'(res_id), 32'(exp_q[0].id));
            chk("stall_data", 32'(res_data), 32'(exp_q[0].data));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1.
   task automatic issue(input int id, input logic [N-1:0] a, input logic [M-1:0] b,
                        input logic [W-1:0] ex, input bit lat);
      int   waitc = 0;
      exp_t e;
      req_a[id*N +: N] = a;
      req_b[id*M +: M] = b;
      req_valid        = '0;
      req_valid[id]    = 1'b1;
      @(negedge clk);
      while (!req_ready[id] && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!req_ready[id]) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: requester %0d never granted", id);
      end else begin
         e.id   = 2'(id);
         e.data = ex;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1 req_valid = '0;
      if (lat) begin
         @(negedge clk);
         chk("lat_k1_not_valid", 32'(res_valid), 0);
         @(negedge clk);
         chk("lat_k2_valid", 32'(res_valid), 1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || res_valid) && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_queue_empty", 32'(exp_q.size()), 0);
   endtask

   task automatic do_reset();
      drain();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;
      #2;
      chk("reset_res_valid", 32'(res_valid), 0);
      chk("reset_res_data", 32'(res_data), 0);
      chk("reset_res_id", 32'(res_id), 0);
      chk("reset_req_ready", 32'(req_ready), 0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed signed vectors with hand-computed products.
      issue(2, 5'b10000, 5'b10000, 10'h100, 1'b1);
      issue(0, 5'd15, 5'b10000, 10'h310, 1'b0);
      issue(0, 5'd0, 5'b11001, 10'h000, 1'b0);
      drain();

      // Round-robin with all requesters active.
      use_model = 1'b1;
      do_reset();
      req_valid = 4'hF;
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_a = 20'($urandom);
         req_b = 20'($urandom);
         @(negedge clk);
         chk("rr_onehot", 32'($countones(req_ready)), 1);
         chk("rr_order", 32'(gidx(req_ready)), 32'(i % 4));
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      drain();

      // Backpressure: two accepts fill the pipe, then all ready bits drop.
      do_reset();
      begin
         int acc0;
         acc0      = acc_cnt;
         req_valid = 4'hF;
         res_ready = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) chk("bp_ready_low", 32'(req_ready), 0);
            @(posedge clk);
            #1;
         end
         chk("bp_accepts", 32'(acc_cnt - acc0), 2);
      end
      res_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      drain();

      // Asynchronous reset with both stages full.
      do_reset();
      req_valid = 4'b0011;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("pre_rst_valid", 32'(res_valid), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(res_valid), 0);
      chk("async_rst_ready", 32'(req_ready), 0);
      chk("async_rst_data", 32'(res_data), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      req_valid = 4'b1010;
      res_ready = 1'b1;
      rst       = 1'b0;
      @(negedge clk);
      chk("post_rst_grant", 32'(req_ready), 32'h2);
      @(posedge clk);
      #1 req_valid = '0;
      drain();

      // Random regression.
      for (int i = 0; i < 1000; i++) begin
         req_valid = 4'($urandom);
         req_a     = 20'($urandom);
         req_b     = 20'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      res_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
